// File: rtl/seven_seg_scan_monitor_if.sv
// Bus between a multiplexed 7-segment display driver and its scan monitor:
// the scanned segment/select lines plus the monitor's decoded results.
interface seven_seg_scan_monitor_if;
    logic [7:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic [3:0]  glyph_err;
    logic        frame_stb;
    logic        sel_err;
    logic        stall;

    modport master (
        output seg_in, sel_in,
        input  digits_out, dp_out, glyph_err, frame_stb, sel_err, stall
    );

    modport slave (
        input  seg_in, sel_in,
        output digits_out, dp_out, glyph_err, frame_stb, sel_err, stall
    );
endinterface

// File: rtl/seven_seg_scan_monitor.sv
// Samples a multiplexed active-low 7-segment scan, rebuilds the four shown
// characters as hex nibbles and flags bad glyphs, illegal selects and stalls.
module seven_seg_scan_monitor #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4194304,
    parameter int CNT_W       = 23
) (
    input logic                      clk,
    input logic                      RESETn,
    seven_seg_scan_monitor_if.slave  bus
);
    localparam int ST_W = $clog2(SETTLE_CYC + 1);
    localparam logic [ST_W-1:0]  SETTLE_V = ST_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TMO_V    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_PRE  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    logic [7:0]       seg_meta_q, seg_s_q, seg_prev_q;
    logic [3:0]       sel_meta_q, sel_s_q, sel_prev_q;
    logic [ST_W-1:0]  stab_q, stab_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    state_t           state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    logic [15:0]      digits_q;
    logic [3:0]       dp_q, gerr_q;
    logic             stb_q, selerr_q, stall_q;

    logic [3:0]  sel_act;
    logic [1:0]  sel_idx;
    logic        sel_blank, sel_one, changed, settled;
    logic        capture, set_selerr, timeout_hit, publish;
    logic [4:0]  dec;
    logic [15:0] shd_nib_w;
    logic [3:0]  shd_dp_w, shd_ge_w;

    // Returns {error, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        sel_act   = ~sel_s_q;
        sel_blank = (sel_act == 4'b0000);
        sel_one   = !sel_blank && ((sel_act & (sel_act - 4'd1)) == 4'b0000);
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sel_act[i]) sel_idx = 2'(i);
        end
        changed = (seg_s_q != seg_prev_q) || (sel_s_q != sel_prev_q);
        settled = (stab_q == SETTLE_V) && !changed;
        dec     = decode(~seg_s_q[6:0]);
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        set_selerr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sel_blank) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (sel_blank) begin
                    state_d = S_IDLE;
                end else if (settled) begin
                    capture    = sel_one;
                    set_selerr = !sel_one;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (changed) state_d = sel_blank ? S_IDLE : S_SETTLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stability run length is tracked independently of state so a change
    // seen while in IDLE or HOLD already starts the settle count.
    always_comb begin
        stab_d = stab_q;
        if (changed)
            stab_d = ST_W'(1);
        else if (stab_q != SETTLE_V)
            stab_d = stab_q + ST_W'(1);

        timeout_hit = !capture && (tmo_q == TMO_PRE);
        if (capture)
            tmo_d = '0;
        else if (tmo_q == TMO_V)
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + CNT_W'(1);

        publish = (mask_q == 4'hF);
        mask_d  = mask_q;
        if (publish || timeout_hit) mask_d = 4'b0000;
        if (capture) mask_d[sel_idx] = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            logic [3:0] nib_q;
            logic       dp_sh_q, ge_sh_q;
            always_ff @(posedge clk or negedge RESETn) begin
                if (!RESETn) begin
                    nib_q   <= 4'h0;
                    dp_sh_q <= 1'b0;
                    ge_sh_q <= 1'b0;
                end else if (capture && (sel_idx == 2'(gi))) begin
                    nib_q   <= dec[3:0];
                    dp_sh_q <= ~seg_s_q[7];
                    ge_sh_q <= dec[4];
                end
            end
            assign shd_nib_w[gi*4 +: 4] = nib_q;
            assign shd_dp_w[gi]         = dp_sh_q;
            assign shd_ge_w[gi]         = ge_sh_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            seg_meta_q <= '1;
            seg_s_q    <= '1;
            seg_prev_q <= '1;
            sel_meta_q <= '1;
            sel_s_q    <= '1;
            sel_prev_q <= '1;
            state_q    <= S_IDLE;
            stab_q     <= '0;
            tmo_q      <= '0;
            mask_q     <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            gerr_q     <= '0;
            stb_q      <= 1'b0;
            selerr_q   <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            seg_meta_q <= bus.seg_in;
            seg_s_q    <= seg_meta_q;
            seg_prev_q <= seg_s_q;
            sel_meta_q <= bus.sel_in;
            sel_s_q    <= sel_meta_q;
            sel_prev_q <= sel_s_q;
            state_q    <= state_d;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            mask_q     <= mask_d;
            stb_q      <= publish;
            if (publish) begin
                digits_q <= shd_nib_w;
                dp_q     <= shd_dp_w;
                gerr_q   <= shd_ge_w;
            end
            if (set_selerr) selerr_q <= 1'b1;
            if (capture)
                stall_q <= 1'b0;
            else if (timeout_hit)
                stall_q <= 1'b1;
        end
    end

    assign bus.digits_out = digits_q;
    assign bus.dp_out     = dp_q;
    assign bus.glyph_err  = gerr_q;
    assign bus.frame_stb  = stb_q;
    assign bus.sel_err    = selerr_q;
    assign bus.stall      = stall_q;
endmodule

// File: tb/tb_seven_seg_scan_monitor.sv
// Directed bench for the 7-segment scan monitor with a run-length based
// reference model checked against the DUT on every falling edge.
module tb_seven_seg_scan_monitor;
    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic clk    = 1'b0;
    logic RESETn = 1'b0;
    always #10 clk = ~clk;

    seven_seg_scan_monitor_if bus();

    seven_seg_scan_monitor #(
        .SETTLE_CYC (SETTLE),
        .TIMEOUT_CYC(TMO),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .RESETn(RESETn),
        .bus   (bus)
    );

    int n_chk   = 0;
    int n_pass  = 0;
    int stb_cnt = 0;
    int base;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: a (sel, seg) pair sampled unchanged on SETTLE+1 consecutive
    // edges is acted on two edges after the last of those samples.
    logic [3:0]  h_sel [3];
    logic [7:0]  h_seg [3];
    int          h_run [3];
    logic [3:0]  m_sh_nib [4];
    logic [3:0]  m_sh_dp, m_sh_ge, m_mask, m_dp, m_gerr, m_act;
    logic [15:0] m_digits;
    logic        m_stb, m_selerr, m_stall, m_cap;
    logic [6:0]  m_pat;
    logic [3:0]  m_nib;
    logic        m_err;
    int          m_tmo, m_run, m_k;

    always @(posedge clk) begin
        if (!RESETn) begin
            for (int i = 0; i < 3; i++) begin
                h_sel[i] = 4'hF; h_seg[i] = 8'hFF; h_run[i] = 1000;
            end
            for (int i = 0; i < 4; i++) m_sh_nib[i] = 4'h0;
            m_sh_dp = 0; m_sh_ge = 0; m_mask = 0; m_dp = 0; m_gerr = 0;
            m_digits = 0; m_stb = 0; m_selerr = 0; m_stall = 0; m_tmo = 0;
        end else begin
            m_run = (bus.sel_in == h_sel[0] && bus.seg_in == h_seg[0]) ?
                    ((h_run[0] >= 1000) ? 1000 : h_run[0] + 1) : 1;
            h_sel[2] = h_sel[1]; h_seg[2] = h_seg[1]; h_run[2] = h_run[1];
            h_sel[1] = h_sel[0]; h_seg[1] = h_seg[0]; h_run[1] = h_run[0];
            h_sel[0] = bus.sel_in; h_seg[0] = bus.seg_in; h_run[0] = m_run;

            m_cap = 1'b0;
            m_k   = 0;
            m_act = ~h_sel[2];
            if (h_run[2] == SETTLE + 1) begin
                if ($countones(m_act) == 1) begin
                    m_cap = 1'b1;
                    for (int i = 0; i < 4; i++) if (m_act[i]) m_k = i;
                end else if ($countones(m_act) > 1) begin
                    m_selerr = 1'b1;
                end
            end

            m_stb = 1'b0;
            if (m_mask == 4'hF) begin
                m_digits = {m_sh_nib[3], m_sh_nib[2], m_sh_nib[1], m_sh_nib[0]};
                m_dp     = m_sh_dp;
                m_gerr   = m_sh_ge;
                m_stb    = 1'b1;
                m_mask   = 4'h0;
            end

            if (m_cap) begin
                m_pat = ~h_seg[2][6:0];
                m_nib = 4'h0; m_err = 1'b1;
                for (int i = 0; i < 16; i++)
                    if (glyph_tab[i] == m_pat) begin m_nib = 4'(i); m_err = 1'b0; end
                m_sh_nib[m_k] = m_nib;
                m_sh_dp[m_k]  = ~h_seg[2][7];
                m_sh_ge[m_k]  = m_err;
                m_mask[m_k]   = 1'b1;
                m_tmo   = 0;
                m_stall = 1'b0;
            end else if (m_tmo < TMO) begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    m_stall = 1'b1;
                    m_mask  = 4'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (RESETn) begin
            chk("digits_out", bus.digits_out, m_digits);
            chk("dp_out",     16'(bus.dp_out),    16'(m_dp));
            chk("glyph_err",  16'(bus.glyph_err), 16'(m_gerr));
            chk("frame_stb",  16'(bus.frame_stb), 16'(m_stb));
            chk("sel_err",    16'(bus.sel_err),   16'(m_selerr));
            chk("stall",      16'(bus.stall),     16'(m_stall));
            if (bus.frame_stb) stb_cnt++;
        end
    end

    task automatic scan(input logic [3:0] s, input logic [7:0] g, input int n);
        bus.sel_in = s;
        bus.seg_in = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_0123();
        scan(4'hE, 8'hC0, 20); scan(4'hD, 8'hF9, 20);
        scan(4'hB, 8'hA4, 20); scan(4'h7, 8'hB0, 20);
        scan(4'hF, 8'hFF, 5);
    endtask

    initial begin
        bus.sel_in = 4'hF;
        bus.seg_in = 8'hFF;
        RESETn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", bus.digits_out, 16'h0000);
        chk("rst_stall",  16'(bus.stall),     16'h0);
        chk("rst_selerr", 16'(bus.sel_err),   16'h0);
        chk("rst_stb",    16'(bus.frame_stb), 16'h0);
        RESETn = 1'b1;

        base = stb_cnt;
        frame_0123();
        chk("t1_frames", 16'(stb_cnt - base), 16'd1);
        chk("t1_digits", bus.digits_out, 16'h3210);
        chk("t1_dp",     16'(bus.dp_out),    16'h0);
        chk("t1_gerr",   16'(bus.glyph_err), 16'h0);

        base = stb_cnt;
        scan(4'hE, 8'h88, 20); scan(4'hD, 8'h83, 20);
        scan(4'hB, 8'h46, 20); scan(4'h7, 8'hA1, 20);
        scan(4'hF, 8'hFF, 5);
        chk("t2_frames", 16'(stb_cnt - base), 16'd1);
        chk("t2_digits", bus.digits_out, 16'hDCBA);
        chk("t2_dp",     16'(bus.dp_out), 16'h4);

        base = stb_cnt;
        scan(4'hE, 8'hC0, 10); scan(4'hE, 8'h80, 2); scan(4'hE, 8'hC0, 10);
        scan(4'hD, 8'hF9, 20); scan(4'hB, 8'hFF, 20); scan(4'h7, 8'hB0, 20);
        scan(4'hF, 8'hFF, 5);
        chk("t3_frames", 16'(stb_cnt - base), 16'd1);
        chk("t3_digits", bus.digits_out, 16'h3010);
        chk("t3_nib2",   16'(bus.digits_out[11:8]), 16'h0);
        chk("t3_gerr",   16'(bus.glyph_err), 16'h4);

        base = stb_cnt;
        scan(4'hC, 8'hC0, 20); scan(4'hF, 8'hFF, 5);
        chk("t4_selerr", 16'(bus.sel_err), 16'h1);
        chk("t4_noframe", 16'(stb_cnt - base), 16'd0);
        frame_0123();
        chk("t4_frames", 16'(stb_cnt - base), 16'd1);
        chk("t4_sticky", 16'(bus.sel_err), 16'h1);
        chk("t4_digits", bus.digits_out, 16'h3210);

        scan(4'hE, 8'hC0, 20); scan(4'hD, 8'hF9, 20);
        scan(4'hF, 8'hFF, 150);
        chk("t5_stall", 16'(bus.stall), 16'h1);
        base = stb_cnt;
        scan(4'hB, 8'h99, 20);
        chk("t5_unstall", 16'(bus.stall), 16'h0);
        scan(4'h7, 8'h92, 20);
        chk("t5_noframe", 16'(stb_cnt - base), 16'd0);
        scan(4'hE, 8'h82, 20); scan(4'hD, 8'hF8, 20); scan(4'hF, 8'hFF, 5);
        chk("t5_frames", 16'(stb_cnt - base), 16'd1);
        chk("t5_digits", bus.digits_out, 16'h5476);

        scan(4'hE, 8'hC0, 20); scan(4'hD, 8'hF9, 20); scan(4'hB, 8'hA4, 20);
        RESETn = 1'b0;
        #1;
        chk("t6_digits", bus.digits_out, 16'h0000);
        chk("t6_dp",     16'(bus.dp_out),    16'h0);
        chk("t6_gerr",   16'(bus.glyph_err), 16'h0);
        chk("t6_selerr", 16'(bus.sel_err),   16'h0);
        chk("t6_stall",  16'(bus.stall),     16'h0);
        bus.sel_in = 4'hF;
        bus.seg_in = 8'hFF;
        repeat (3) @(negedge clk);
        RESETn = 1'b1;
        base = stb_cnt;
        frame_0123();
        chk("t6_frames", 16'(stb_cnt - base), 16'd1);
        chk("t6_after",  bus.digits_out, 16'h3210);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
